cdc_handshake_src: RTL

//   Source (transmit) end of a 2-phase toggle, bundled-data clock domain crossing.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/cdc_bit_sync.sv | 23 ++
 rtl/cdc_handshake_src.sv | 113 +++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake clock domain crossing blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    BUSY
  } cdc_src_state_e;

  localparam int unsigned CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-stage single-bit synchroniser with synchronous active-low reset.
module cdc_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstN_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] syncQ;

  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], d_i};
    end
  end

  assign q_o = syncQ[STAGES-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// Source end of a 2-phase toggle, bundled-data CDC: valid/ready in, held data plus
// request toggle out, completion on the synchronised acknowledge toggle.
module cdc_handshake_src
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             srcClk_i,
  input  logic             srcRstN_i,
  input  logic             srcValid_i,
  output logic             srcReady_o,
  input  logic [WIDTH-1:0] srcData_i,
  output logic             srcDone_o,
  output logic             srcTimeout_o,
  output logic             xReq_o,
  output logic [WIDTH-1:0] xData_o,
  input  logic             xAck_i
);

  localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

  generate
    if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : gBadSyncStages
      $error("cdc_handshake_src: SYNC_STAGES must be >= %0d", CDC_MIN_SYNC_STAGES);
    end
  endgenerate

  cdc_src_state_e   state, stateNxt;
  logic             ackS;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             readyNxt, doneNxt, reqNxt, timeoutNxt;
  logic [WIDTH-1:0] dataNxt;

  cdc_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) uAckSync (
    .clk_i  (srcClk_i),
    .rstN_i (srcRstN_i),
    .d_i    (xAck_i),
    .q_o    (ackS)
  );

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    stateNxt   = state;
    readyNxt   = 1'b0;
    doneNxt    = 1'b0;
    reqNxt     = xReq_o;
    dataNxt    = xData_o;
    cntNxt     = cnt;
    timeoutNxt = srcTimeout_o;
    case (state)
      RESYNC: begin
        if (ackS == xReq_o) begin
          stateNxt = IDLE;
          readyNxt = 1'b1;
        end
      end
      IDLE: begin
        readyNxt = 1'b1;
        if (ackS != xReq_o) begin
          stateNxt = RESYNC;
          readyNxt = 1'b0;
        end else if (srcValid_i && srcReady_o) begin
          dataNxt  = srcData_i;
          reqNxt   = ~xReq_o;
          cntNxt   = '0;
          readyNxt = 1'b0;
          stateNxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != CNT_MAX) begin
          cntNxt = cnt + 1'b1;
        end
        if (TO_EN && (cntNxt == CNT_MAX)) begin
          timeoutNxt = 1'b1;
        end
        if (ackS == xReq_o) begin
          doneNxt  = 1'b1;
          readyNxt = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = RESYNC;
    endcase
  end

  always_ff @(posedge srcClk_i) begin
    if (!srcRstN_i) begin
      state        <= RESYNC;
      srcReady_o   <= 1'b0;
      srcDone_o    <= 1'b0;
      srcTimeout_o <= 1'b0;
      xReq_o       <= 1'b0;
      xData_o      <= '0;
      cnt          <= '0;
    end else begin
      state        <= stateNxt;
      srcReady_o   <= readyNxt;
      srcDone_o    <= doneNxt;
      srcTimeout_o <= timeoutNxt;
      xReq_o       <= reqNxt;
      xData_o      <= dataNxt;
      cnt          <= cntNxt;
    end
  end

endmodule
